// File: rtl/mul_unit.sv
// mul_unit: multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the EX stage.
// Radix-2 shift-add over unsigned magnitudes, sign fixed up in a final step.
// Fixed latency: done pulses XLEN+1 edges after the accepting edge.
//
// Ports:
//   clk     clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   mulctl  op select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    rs1 / rs2 operands, sampled on the accepting edge
//   res     registered result, held until the next SIGN step
//   done    one-cycle pulse, res valid while high
//   busy    high whenever not in IDLE
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            done,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t              state, state_nx;
    logic [1:0]          op;
    logic                neg;
    logic [XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]   prod;   // upper half accumulates, lower half holds the multiplier
    logic [CW-1:0]       cnt;

    logic                sa, sb;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   prod_step, prod_fin;

    // Operand signedness: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
    // MUL takes the unsigned path since its low half is sign-agnostic.
    assign sa    = ((mulctl == 2'b01) || (mulctl == 2'b10)) && a[XLEN-1];
    assign sb    = (mulctl == 2'b01) && b[XLEN-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;

    // Add into the upper half keeping the carry, then shift the whole product right.
    assign sum       = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {sum, prod[XLEN-1:1]};
    assign prod_fin  = neg ? -prod : prod;

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CW'(XLEN - 1)) state_nx = SIGN;
            SIGN:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= '0;
            neg   <= 1'b0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            res   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= mulctl;
                        neg   <= sa ^ sb;
                        mcand <= a_mag;
                        prod  <= {{XLEN{1'b0}}, b_mag};
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    prod <= prod_step;
                    cnt  <= cnt + CW'(1);
                end
                SIGN: begin
                    res  <= (op == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
                    done <= 1'b1;
                end
                DONE: done <= 1'b0;
                default: done <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mulctl = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic [31:0] res;
    logic        done, busy;

    int checks = 0;
    int errors = 0;

    mul_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mulctl(mulctl),
        .a(a), .b(b), .res(res), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 64 bits and multiply; pick the half by op.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = (op == 2'b01 || op == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (op == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op with a single-cycle start; report result, edges from accept to done,
    // whether busy stayed high throughout, and done/busy one edge after the pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output logic busy_ok,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        mulctl = op; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = busy;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (done) break;
            busy_ok &= busy;
        end
        busy_ok &= busy;
        if (!done) lat = -1;
        r = res;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got=%h exp=0", res); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
        logic [31:0] xs  [6] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] ys  [6] = '{32'd6, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] exps[6] = '{32'd42, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
        logic [31:0] r; int lat; logic bok, da, ba;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], r, lat, bok, da, ba);
            checks++; if (r !== exps[i]) begin errors++; $display("FAIL directed_res[%0d] got=%h exp=%h", i, r, exps[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL directed_lat[%0d] got=%0d exp=33", i, lat); end
            checks++; if (!bok) begin errors++; $display("FAIL directed_busy[%0d] got=0 exp=1", i); end
            checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL directed_pulse[%0d] done=%b busy=%b exp=0/0", i, da, ba); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, x, y; logic [1:0] op; int lat; logic bok, da, ba;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = $urandom; y = $urandom;
            if (i % 6 == 0) x = 32'h80000000;
            if (i % 8 == 1) y = 32'h0;
            run_op(op, x, y, r, lat, bok, da, ba);
            checks++; if (r !== model(op, x, y)) begin errors++; $display("FAIL random_res op=%0d a=%h b=%h got=%h exp=%h", op, x, y, r, model(op, x, y)); end
            checks++; if (lat != 33 || da !== 1'b0) begin errors++; $display("FAIL random_timing lat=%0d done_after=%b exp=33/0", lat, da); end
        end
    endtask

    task automatic test_ignore_inputs();
        int lat = 0; int pulses = 0;
        @(negedge clk);
        mulctl = 2'b11; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (lat == 10) begin a = $urandom; b = $urandom; mulctl = 2'b00; start = 1'b1; end
            if (lat == 11) start = 1'b0;
            if (done) break;
        end
        checks++; if (!done || lat != 33) begin errors++; $display("FAIL ignore_lat got=%0d exp=33", lat); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL ignore_res got=%h exp=0", res); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_second_op pulses=%0d busy=%b exp=0/0", pulses, busy); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int lat; logic bok, da, ba;
        run_op(2'b00, 32'd7, 32'd6, r, lat, bok, da, ba);
        @(negedge clk);
        mulctl = 2'b00; a = 32'h12345; b = 32'h6789; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL async_rst_res got=%h exp=0", res); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_ctl done=%b busy=%b exp=0/0", done, busy); end
        @(negedge clk); rst_n = 1'b1;
        run_op(2'b00, 32'd2, 32'd3, r, lat, bok, da, ba);
        checks++; if (r !== 32'd6 || lat != 33) begin errors++; $display("FAIL async_rst_after res=%h lat=%0d exp=6/33", r, lat); end
    endtask

    task automatic test_back_to_back();
        int last = -1; int n = 0; int w = 0;
        @(negedge clk);
        mulctl = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            if (done) begin
                checks++; if (res !== 32'd25) begin errors++; $display("FAIL b2b_res got=%h exp=25", res); end
                if (last >= 0) begin
                    checks++; if (c - last != 35) begin errors++; $display("FAIL b2b_period got=%0d exp=35", c - last); end
                end
                last = c; n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
        // drain the op accepted while start was still held
        start = 1'b0;
        while (!done && w < 60) begin @(posedge clk); w++; #1; end
        checks++; if (!done) begin errors++; $display("FAIL b2b_drain got=timeout exp=done"); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [31:0] r; int lat; logic bok, da, ba;
        run_op(2'b01, 32'h0, 32'h80000000, r, lat, bok, da, ba);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL zero_res got=%h exp=0", r); end
        checks++; if (lat != 33) begin errors++; $display("FAIL zero_lat got=%0d exp=33", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_inputs();
        test_async_reset();
        test_back_to_back();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
